// File: rtl/hififo_pio_regs_if.sv
// PIO bus between pcie_rx/pcie_tx and the register block: posted writes,
// read requests and completion return.
interface hififo_pio_regs_if;
  logic        wr_valid;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rr_valid;
  logic        rr_ready;
  logic [5:0]  rr_addr;
  logic        rc_valid;
  logic        rc_ready;
  logic [31:0] rc_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rr_valid, rr_addr, rc_ready,
    input  rr_ready, rc_valid, rc_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rr_valid, rr_addr, rc_ready,
    output rr_ready, rc_valid, rc_data
  );
endinterface

// File: rtl/hififo_pio_regs.sv
// HIFIFO PIO control/status registers: per-channel soft reset, masked
// interrupt status with W1C / clear-on-read, irq toward core, read FSM.

module hififo_pio_regs_chan #(
  parameter bit EN = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic ev_i,
  input  logic clr_i,
  input  logic mask_we_i,
  input  logic mask_wd_i,
  input  logic rst_set_i,
  input  logic rst_clr_i,
  output logic stat_o,
  output logic mask_o,
  output logic rst_o
);
  if (EN) begin : g_on
    logic stat_q, stat_d, mask_q, mask_d, rst_q, rst_d;

    // A fresh event always beats a same-cycle clear so none is lost.
    always_comb begin
      stat_d = (stat_q & ~clr_i) | ev_i;
      mask_d = mask_we_i ? mask_wd_i : mask_q;
      rst_d  = rst_q;
      if (rst_set_i)      rst_d = 1'b1;
      else if (rst_clr_i) rst_d = 1'b0;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        stat_q <= 1'b0;
        mask_q <= 1'b1;
        rst_q  <= 1'b1;
      end else begin
        stat_q <= stat_d;
        mask_q <= mask_d;
        rst_q  <= rst_d;
      end
    end

    assign stat_o = stat_q;
    assign mask_o = mask_q;
    assign rst_o  = rst_q;
  end else begin : g_off
    logic unused_in;
    assign unused_in = ^{clock, reset, ev_i, clr_i, mask_we_i, mask_wd_i,
                         rst_set_i, rst_clr_i};
    assign stat_o = 1'b0;
    assign mask_o = 1'b0;
    assign rst_o  = 1'b1;
  end
endmodule

module hififo_pio_regs #(
  parameter int               NFIFO         = 8,
  parameter logic [NFIFO-1:0] ENABLE        = 8'h11,
  parameter bit               CLEAR_ON_READ = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  hififo_pio_regs_if.slave       bus,
  input  logic [32*NFIFO-1:0]    status,
  input  logic [NFIFO-1:0]       interrupt_individual,
  output logic [NFIFO-1:0]       fifo_reset,
  output logic                   irq,
  input  logic                   irq_rdy
);
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, ACK} state_e;

  localparam logic [31:0] ID_WORD = 32'({8'd0, 8'(NFIFO), ENABLE});

  state_e                  state_q, state_d;
  logic [31:0]             rc_data_q, rc_data_d;
  logic [31:0]             scratch_q, scratch_d;
  logic                    irq_q, irq_d;
  logic [NFIFO-1:0]        int_status, int_mask;
  logic [NFIFO-1:0]        cor_clr, st_clr;
  logic [NFIFO-1:0][31:0]  stat_w;
  logic [31:0]             rd_val;
  logic                    we2, we3, we4, we5, we6;
  logic                    unused_wr;

  assign we2 = bus.wr_valid && (bus.wr_addr == 6'd2);
  assign we3 = bus.wr_valid && (bus.wr_addr == 6'd3);
  assign we4 = bus.wr_valid && (bus.wr_addr == 6'd4);
  assign we5 = bus.wr_valid && (bus.wr_addr == 6'd5);
  assign we6 = bus.wr_valid && (bus.wr_addr == 6'd6);
  assign unused_wr = ^bus.wr_data[63:32];

  assign st_clr = (we5 ? bus.wr_data[NFIFO-1:0] : '0) | cor_clr;

  for (genvar gi = 0; gi < NFIFO; gi++) begin : g_ch
    hififo_pio_regs_chan #(.EN(ENABLE[gi])) u_chan (
      .clock     (clock),
      .reset     (reset),
      .ev_i      (interrupt_individual[gi]),
      .clr_i     (st_clr[gi]),
      .mask_we_i (we2),
      .mask_wd_i (bus.wr_data[gi]),
      .rst_set_i (we3 && bus.wr_data[gi]),
      .rst_clr_i (we4 && bus.wr_data[gi]),
      .stat_o    (int_status[gi]),
      .mask_o    (int_mask[gi]),
      .rst_o     (fifo_reset[gi])
    );
    assign stat_w[gi] = ENABLE[gi] ? status[32*gi +: 32] : 32'd0;
  end

  assign scratch_d = we6 ? bus.wr_data[31:0] : scratch_q;

  // Events outrank the core's acknowledge so a late event re-arms irq.
  always_comb begin
    irq_d = irq_q;
    if (|(interrupt_individual & int_mask & ENABLE)) irq_d = 1'b1;
    else if (irq_rdy)                                irq_d = 1'b0;
  end

  always_comb begin
    rd_val = 32'd0;
    case (bus.rr_addr)
      6'd0:       rd_val = 32'(int_status);
      6'd1:       rd_val = ID_WORD;
      6'd2:       rd_val = 32'(int_mask);
      6'd3, 6'd4: rd_val = 32'(fifo_reset);
      6'd5:       rd_val = 32'(int_status);
      6'd6:       rd_val = scratch_q;
      default: begin
        for (int i = 0; i < NFIFO; i++)
          if (bus.rr_addr == 6'(8 + i)) rd_val = stat_w[i];
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rc_data_d    = rc_data_q;
    cor_clr      = '0;
    bus.rc_valid = 1'b0;
    bus.rr_ready = 1'b0;
    case (state_q)
      IDLE:   if (bus.rr_valid) state_d = LOOKUP;
      LOOKUP: begin
        rc_data_d = rd_val;
        if (CLEAR_ON_READ && (bus.rr_addr == 6'd0)) cor_clr = int_status;
        state_d = RESP;
      end
      RESP: begin
        bus.rc_valid = 1'b1;
        if (bus.rc_ready) state_d = ACK;
      end
      ACK: begin
        bus.rr_ready = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rc_data_q <= 32'd0;
      scratch_q <= 32'd0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rc_data_q <= rc_data_d;
      scratch_q <= scratch_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.rc_data = rc_data_q;
  assign irq         = irq_q;
endmodule

// File: tb/tb_hififo_pio_regs.sv
// Directed bench for hififo_pio_regs with NFIFO=8, ENABLE=8'h11, CLEAR_ON_READ=1.
module tb_hififo_pio_regs;
  localparam int NFIFO = 8;
  localparam logic [7:0] ENABLE = 8'h11;

  logic clock = 1'b0;
  logic reset;
  logic [32*NFIFO-1:0] status;
  logic [NFIFO-1:0] interrupt_individual;
  logic [NFIFO-1:0] fifo_reset;
  logic irq, irq_rdy;
  int n_checks = 0;
  int n_fail = 0;

  hififo_pio_regs_if bus();

  hififo_pio_regs #(.NFIFO(NFIFO), .ENABLE(ENABLE), .CLEAR_ON_READ(1'b1)) dut (
    .clock                (clock),
    .reset                (reset),
    .bus                  (bus),
    .status               (status),
    .interrupt_individual (interrupt_individual),
    .fifo_reset           (fifo_reset),
    .irq                  (irq),
    .irq_rdy              (irq_rdy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [63:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
  endtask

  // Full read handshake; returns data, cycles to rc_valid, rr_ready pulse count
  // and whether rc_valid/rc_data held steady while rc_ready was withheld.
  task automatic do_read(input logic [5:0] a, input int hold,
                         output logic [31:0] d, output int lat,
                         output int nrdy, output bit stable);
    bus.rr_addr  = a;
    bus.rr_valid = 1'b1;
    lat = -1;
    stable = 1'b1;
    nrdy = 0;
    d = 'x;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.rc_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      bus.rr_valid = 1'b0;
      return;
    end
    d = bus.rc_data;
    for (int c = 0; c < hold; c++) begin
      tick();
      if (bus.rc_valid !== 1'b1 || bus.rc_data !== d || bus.rr_ready !== 1'b0)
        stable = 1'b0;
    end
    bus.rc_ready = 1'b1;
    tick();
    bus.rc_ready = 1'b0;
    if (bus.rc_valid !== 1'b0) stable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.rr_ready === 1'b1) begin
        nrdy++;
        bus.rr_valid = 1'b0;
      end
      tick();
    end
    bus.rr_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat, nrdy;
    bit st;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (bus.rr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rr_ready: got %b want 0", bus.rr_ready); end
    n_checks++; if (bus.rc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rc_valid: got %b want 0", bus.rc_valid); end
    n_checks++; if (bus.rc_data !== 32'd0) begin n_fail++; $display("FAIL reset_rc_data: got %h want 0", bus.rc_data); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_checks++; if (fifo_reset !== 8'hFF) begin n_fail++; $display("FAIL reset_fifo_reset: got %h want ff", fifo_reset); end
    do_read(6'd5, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_int_status: got %h want 0", d); end
    do_read(6'd2, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h11) begin n_fail++; $display("FAIL reset_int_mask: got %h want 11", d); end
    do_read(6'd6, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_scratch: got %h want 0", d); end
  endtask

  task automatic test_id();
    logic [31:0] d;
    int lat, nrdy;
    bit st;
    do_read(6'd1, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h0000_0811) begin n_fail++; $display("FAIL id_data: got %h want 00000811", d); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL id_latency: got %0d want 2", lat); end
    n_checks++; if (nrdy !== 1) begin n_fail++; $display("FAIL id_rr_ready_pulses: got %0d want 1", nrdy); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL id_rc_valid_drop: got %b want 1", st); end
  endtask

  task automatic test_fifo_reset();
    logic [31:0] d;
    int lat, nrdy;
    bit st;
    do_write(6'd4, 64'hFF);
    n_checks++; if (fifo_reset !== 8'hEE) begin n_fail++; $display("FAIL frst_clr_port: got %h want ee", fifo_reset); end
    do_read(6'd3, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'hEE) begin n_fail++; $display("FAIL frst_read3: got %h want ee", d); end
    do_read(6'd4, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'hEE) begin n_fail++; $display("FAIL frst_read4: got %h want ee", d); end
    do_write(6'd3, 64'h10);
    n_checks++; if (fifo_reset !== 8'hFE) begin n_fail++; $display("FAIL frst_set: got %h want fe", fifo_reset); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int lat, nrdy;
    bit st;
    interrupt_individual = 8'h01;
    tick();
    interrupt_individual = 8'h00;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold c%0d: got %b want 1", c, irq); end
    end
    tick();
    irq_rdy = 1'b1;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold c5: got %b want 1", irq); end
    tick();
    irq_rdy = 1'b0;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_ack: got %b want 0", irq); end
    interrupt_individual = 8'h01;
    tick();
    irq_rdy = 1'b1;
    tick();
    interrupt_individual = 8'h00;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_event_beats_rdy: got %b want 1", irq); end
    tick();
    irq_rdy = 1'b0;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_ack2: got %b want 0", irq); end
    do_read(6'd5, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL irq_status: got %h want 01", d); end
    do_write(6'd5, 64'h01);
    do_read(6'd5, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h00) begin n_fail++; $display("FAIL w1c_status: got %h want 00", d); end
    do_write(6'd2, 64'hFF);
    do_read(6'd2, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h11) begin n_fail++; $display("FAIL mask_disabled_bits: got %h want 11", d); end
    do_write(6'd2, 64'h00);
    interrupt_individual = 8'h03;
    tick();
    interrupt_individual = 8'h00;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", irq); end
    tick();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked2: got %b want 0", irq); end
    do_read(6'd5, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL masked_status: got %h want 01", d); end
    do_write(6'd2, 64'h11);
    do_write(6'd5, 64'hFF);
  endtask

  task automatic test_clear_on_read();
    logic [31:0] d;
    int lat, nrdy;
    bit st;
    interrupt_individual = 8'h10;
    tick();
    interrupt_individual = 8'h00;
    irq_rdy = 1'b1;
    tick();
    irq_rdy = 1'b0;
    bus.rr_addr  = 6'd0;
    bus.rr_valid = 1'b1;
    tick();
    interrupt_individual = 8'h01;
    tick();
    interrupt_individual = 8'h00;
    n_checks++; if (bus.rc_valid !== 1'b1) begin n_fail++; $display("FAIL cor_rc_valid: got %b want 1", bus.rc_valid); end
    n_checks++; if (bus.rc_data !== 32'h10) begin n_fail++; $display("FAIL cor_data: got %h want 10", bus.rc_data); end
    bus.rc_ready = 1'b1;
    tick();
    bus.rc_ready = 1'b0;
    n_checks++; if (bus.rr_ready !== 1'b1) begin n_fail++; $display("FAIL cor_rr_ready: got %b want 1", bus.rr_ready); end
    bus.rr_valid = 1'b0;
    tick();
    do_read(6'd5, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL cor_status_after: got %h want 01", d); end
    do_read(6'd0, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL cor_second_read: got %h want 01", d); end
    do_read(6'd5, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h00) begin n_fail++; $display("FAIL cor_cleared: got %h want 00", d); end
    interrupt_individual = 8'h01;
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 6'd5;
    bus.wr_data  = 64'h01;
    tick();
    bus.wr_valid = 1'b0;
    interrupt_individual = 8'h00;
    do_read(6'd5, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("FAIL event_beats_w1c: got %h want 01", d); end
    do_write(6'd5, 64'hFF);
    irq_rdy = 1'b1;
    tick();
    irq_rdy = 1'b0;
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    int lat, nrdy;
    bit st;
    do_write(6'd6, 64'hFFFF_0000_A5A5_1234);
    do_read(6'd6, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'hA5A5_1234) begin n_fail++; $display("FAIL scratch_rw: got %h want a5a51234", d); end
    bus.rr_addr  = 6'd6;
    bus.rr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 6'd6;
    bus.wr_data  = 64'h0BAD_F00D;
    tick();
    bus.wr_valid = 1'b0;
    n_checks++; if (bus.rc_data !== 32'hA5A5_1234) begin n_fail++; $display("FAIL lookup_excludes_write: got %h want a5a51234", bus.rc_data); end
    bus.rc_ready = 1'b1;
    tick();
    bus.rc_ready = 1'b0;
    bus.rr_valid = 1'b0;
    tick();
    do_write(6'd7, 64'h1234);
    do_read(6'd6, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL scratch_new: got %h want 0badf00d", d); end
    do_read(6'd7, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_7: got %h want 0", d); end
  endtask

  task automatic test_status();
    logic [31:0] d;
    int lat, nrdy;
    bit st;
    status = '0;
    status[4*32 +: 32] = 32'hDEAD_BEEF;
    status[0*32 +: 32] = 32'h1234_5678;
    status[1*32 +: 32] = 32'h0000_CAFE;
    do_read(6'd12, 10, d, lat, nrdy, st);
    n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL status4: got %h want deadbeef", d); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL status4_stable: got %b want 1", st); end
    n_checks++; if (nrdy !== 1) begin n_fail++; $display("FAIL status4_rr_ready: got %0d want 1", nrdy); end
    do_read(6'd8, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL status0: got %h want 12345678", d); end
    do_read(6'd9, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL status1_disabled: got %h want 0", d); end
    do_read(6'd16, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL status_out_of_range: got %h want 0", d); end
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] d;
    int lat, nrdy, seen;
    bit st;
    interrupt_individual = 8'h10;
    tick();
    interrupt_individual = 8'h00;
    bus.rr_addr  = 6'd12;
    bus.rr_valid = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.rc_valid !== 1'b1) begin n_fail++; $display("FAIL rst_resp_entry: got %b want 1", bus.rc_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rr_valid = 1'b0;
    n_checks++; if (bus.rc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_rc_valid: got %b want 0", bus.rc_valid); end
    n_checks++; if (fifo_reset !== 8'hFF) begin n_fail++; $display("FAIL rst_resp_fifo_reset: got %h want ff", fifo_reset); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_resp_irq: got %b want 0", irq); end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.rr_ready !== 1'b0 || bus.rc_valid !== 1'b0) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_resp_no_ack: got %0d want 0", seen); end
    do_read(6'd5, 0, d, lat, nrdy, st);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_resp_int_status: got %h want 0", d); end
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rr_valid = 1'b0;
    bus.rr_addr  = '0;
    bus.rc_ready = 1'b0;
    status = '0;
    interrupt_individual = '0;
    irq_rdy = 1'b0;
    test_reset();
    test_id();
    test_fifo_reset();
    test_irq();
    test_clear_on_read();
    test_scratch();
    test_status();
    test_reset_in_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
